// File: rtl/score_keeper_pkg.sv
// Shared definitions for the Huarong Dao game-statistics engine.
// Holds the FSM state encoding, the display-select codes, the score bus
// width, the blank code, and a saturating-increment helper.
package hd_pkg;

    localparam int unsigned       SCORE_W    = 16;
    localparam logic [SCORE_W-1:0] BLANK_CODE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DISP_MOVES = 2'd0,
        DISP_SECS  = 2'd1,
        DISP_BEST  = 2'd2,
        DISP_BLANK = 2'd3
    } disp_sel_t;

    // The ceiling is checked before adding, so the result never exceeds max_v.
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v,
        input logic [SCORE_W-1:0] max_v
    );
        return (v < max_v) ? v + SCORE_W'(1) : v;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-control and scoreboard signals of score_keeper.
// Signals:
//   I_start      1-cycle pulse: start/restart a game
//   I_move       1-cycle pulse: legal move accepted upstream
//   I_undo       1-cycle pulse: undo last move
//   I_win        level: board is solved
//   I_disp_sel   0=moves 1=seconds 2=best 3=blank
//   O_score      binary score for the scoreboard (16'hFFFF = blank)
//   O_state      0=IDLE 1=PLAY 2=WON
//   O_new_record 1-cycle pulse when the best solve improves
// Modports: master drives the inputs (upstream/bench), slave is score_keeper.
interface score_keeper_if;
    import hd_pkg::*;

    logic               I_start;
    logic               I_move;
    logic               I_undo;
    logic               I_win;
    logic [1:0]         I_disp_sel;
    logic [SCORE_W-1:0] O_score;
    logic [1:0]         O_state;
    logic               O_new_record;

    modport master (
        output I_start, I_move, I_undo, I_win, I_disp_sel,
        input  O_score, O_state, O_new_record
    );

    modport slave (
        input  I_start, I_move, I_undo, I_win, I_disp_sel,
        output O_score, O_state, O_new_record
    );

endinterface

// File: rtl/score_keeper_tick_gen.sv
// Seconds prescaler: counts 0..TICK_DIV-1 while enabled and emits a
// 1-cycle tick in the cycle the count wraps back to 0.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   en_i    count enable (held value when low)
//   clr_i   synchronous clear, overrides enable
//   tick_o  1-cycle pulse on wrap
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-statistics engine for the Huarong Dao board: counts moves and
// elapsed seconds during play, keeps the fewest-move solve, and drives a
// registered binary score bus for the 7-segment scoreboard.
// Ports:
//   I_clk    system clock
//   I_rst_n  asynchronous active-low reset
//   bus      score_keeper_if.slave (game-control inputs, score/state outputs)
module score_keeper
    import hd_pkg::*;
#(
    parameter int unsigned MAX_SCORE = 9999,
    parameter int unsigned TICK_DIV  = 100_000_000
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    score_keeper_if.slave bus
);

    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] moves_q, moves_d;
    logic [SCORE_W-1:0] secs_q, secs_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               best_valid_q, best_valid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               new_record_q, new_record_d;
    logic               tick;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk_i  (I_clk),
        .rst_ni (I_rst_n),
        .en_i   (state_q == ST_PLAY),
        .clr_i  (bus.I_start),
        .tick_o (tick)
    );

    always_comb begin
        state_d      = state_q;
        moves_d      = moves_q;
        secs_d       = secs_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_record_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_WON: begin
                if (bus.I_start) begin
                    state_d = ST_PLAY;
                    moves_d = '0;
                    secs_d  = '0;
                end
            end
            ST_PLAY: begin
                if (bus.I_start) begin
                    moves_d = '0;
                    secs_d  = '0;
                end else begin
                    if (bus.I_move && !bus.I_undo) begin
                        moves_d = sat_inc(moves_q, MAX_V);
                    end else if (bus.I_undo && !bus.I_move && moves_q != '0) begin
                        moves_d = moves_q - SCORE_W'(1);
                    end
                    if (tick) begin
                        secs_d = sat_inc(secs_q, MAX_V);
                    end
                    // A move in the winning cycle counts, so compare the updated count.
                    if (bus.I_win) begin
                        state_d = ST_WON;
                        if (!best_valid_q || moves_d < best_q) begin
                            best_d       = moves_d;
                            best_valid_d = 1'b1;
                            new_record_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        score_d = BLANK_CODE;
        unique case (disp_sel_t'(bus.I_disp_sel))
            DISP_MOVES: score_d = moves_q;
            DISP_SECS:  score_d = secs_q;
            DISP_BEST:  score_d = best_valid_q ? best_q : BLANK_CODE;
            DISP_BLANK: score_d = BLANK_CODE;
            default:    score_d = BLANK_CODE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q      <= ST_IDLE;
            moves_q      <= '0;
            secs_q       <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            score_q      <= '0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            moves_q      <= moves_d;
            secs_q       <= secs_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            score_q      <= score_d;
            new_record_q <= new_record_d;
        end
    end

    assign bus.O_score      = score_q;
    assign bus.O_state      = state_q;
    assign bus.O_new_record = new_record_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with TICK_DIV=10.
module tb_score_keeper;
    import hd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    score_keeper_if bus();

    score_keeper #(
        .MAX_SCORE(9999),
        .TICK_DIV (10)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        start;
        logic        move;
        logic        undo;
        logic        win;
        logic [1:0]  sel;
        logic [1:0]  exp_state;
        logic        exp_rec;
        logic [15:0] exp_score;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic m, input logic u, input logic w,
                         input logic [1:0] sel);
        bus.I_start    = s;
        bus.I_move     = m;
        bus.I_undo     = u;
        bus.I_win      = w;
        bus.I_disp_sel = sel;
    endtask

    task automatic idle(input logic [1:0] sel);
        drive(1'b0, 1'b0, 1'b0, 1'b0, sel);
    endtask

    task automatic reset_dut();
        idle(2'd0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic addv(input logic s, input logic m, input logic u, input logic w,
                        input logic [1:0] sel, input logic [1:0] st, input logic rec,
                        input logic [15:0] score);
        vec_t v;
        v.start = s; v.move = m; v.undo = u; v.win = w; v.sel = sel;
        v.exp_state = st; v.exp_rec = rec; v.exp_score = score;
        tbl.push_back(v);
    endtask

    // start, n moves, win; then check the record pulse and the displayed best.
    task automatic play_game(input int n, input logic exp_rec, input logic [15:0] exp_best,
                             input string name);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        chk({name, " state"}, bus.O_state, 2);
        chk({name, " record"}, bus.O_new_record, exp_rec);
        idle(2'd2);
        @(negedge clk);
        chk({name, " record width"}, bus.O_new_record, 0);
        chk({name, " best"}, bus.O_score, exp_best);
    endtask

    initial begin
        idle(2'd0);
        repeat (2) @(negedge clk);
        chk("reset score", bus.O_score, 0);
        chk("reset state", bus.O_state, 0);
        chk("reset record", bus.O_new_record, 0);
        rst_n = 1'b1;

        // Reset while counters are nonzero.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        repeat (3) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            @(negedge clk);
        end
        idle(2'd0);
        @(negedge clk);
        chk("pre-reset moves", bus.O_score, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset score", bus.O_score, 0);
        chk("async reset state", bus.O_state, 0);
        chk("async reset record", bus.O_new_record, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2'd2);
        @(negedge clk);
        chk("reset best blank", bus.O_score, 16'hFFFF);
        chk("reset record idle", bus.O_new_record, 0);

        // Table: move/undo counting, floor, start+win priority, WON freeze.
        //   start move undo win sel  state rec score
        addv(0, 1, 0, 0, 0, 0, 0, 0);        // move ignored in IDLE
        addv(1, 0, 0, 0, 0, 1, 0, 0);
        addv(0, 1, 0, 0, 0, 1, 0, 1);
        addv(0, 1, 0, 0, 0, 1, 0, 2);
        addv(0, 1, 0, 0, 0, 1, 0, 3);
        addv(0, 1, 0, 0, 0, 1, 0, 4);
        addv(0, 1, 0, 0, 0, 1, 0, 5);
        addv(0, 0, 1, 0, 0, 1, 0, 4);
        addv(0, 0, 1, 0, 0, 1, 0, 3);
        addv(0, 0, 1, 0, 0, 1, 0, 2);
        addv(0, 0, 1, 0, 0, 1, 0, 1);
        addv(0, 0, 1, 0, 0, 1, 0, 0);
        addv(0, 0, 1, 0, 0, 1, 0, 0);        // floor at 0
        addv(0, 1, 1, 0, 0, 1, 0, 0);        // move+undo: no change
        addv(0, 1, 0, 0, 0, 1, 0, 1);
        addv(0, 1, 0, 0, 0, 1, 0, 2);
        addv(1, 0, 0, 1, 0, 1, 0, 0);        // start beats win, clears
        addv(0, 0, 0, 1, 0, 2, 1, 0);        // first win: record at 0
        addv(0, 1, 0, 1, 0, 2, 0, 0);        // move/win ignored in WON
        addv(0, 0, 1, 0, 0, 2, 0, 0);
        addv(0, 0, 0, 0, 2, 2, 0, 0);        // best = 0
        addv(0, 0, 0, 0, 3, 2, 0, 16'hFFFF); // blank

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].start, tbl[i].move, tbl[i].undo, tbl[i].win, tbl[i].sel);
            @(negedge clk);
            chk($sformatf("vec%0d state", i), bus.O_state, tbl[i].exp_state);
            chk($sformatf("vec%0d record", i), bus.O_new_record, tbl[i].exp_rec);
            idle(tbl[i].sel);
            @(negedge clk);
            chk($sformatf("vec%0d score", i), bus.O_score, tbl[i].exp_score);
        end

        // Seconds prescaler and freeze in WON.
        reset_dut();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        @(negedge clk);
        idle(2'd1);
        repeat (30) @(negedge clk);
        chk("secs before 3rd tick", bus.O_score, 2);
        @(negedge clk);
        chk("secs after 3rd tick", bus.O_score, 3);
        repeat (4) @(negedge clk);
        chk("secs at 35 cycles", bus.O_score, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        chk("win state", bus.O_state, 2);
        idle(2'd1);
        for (int k = 0; k < 5; k++) begin
            repeat (10) @(negedge clk);
            chk($sformatf("secs frozen %0d", k), bus.O_score, 3);
        end

        // Best tracking across games.
        reset_dut();
        play_game(7, 1'b1, 16'd7, "gameA");
        play_game(7, 1'b0, 16'd7, "gameB");
        play_game(4, 1'b1, 16'd4, "gameC");

        // Move saturation, then move+win in the same cycle.
        reset_dut();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (9999) @(negedge clk);
        idle(2'd0);
        @(negedge clk);
        chk("moves at 9999", bus.O_score, 9999);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        idle(2'd0);
        @(negedge clk);
        chk("moves saturated", bus.O_score, 9999);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        repeat (2) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        chk("move+win state", bus.O_state, 2);
        chk("move+win record", bus.O_new_record, 1);
        idle(2'd2);
        @(negedge clk);
        chk("move+win best", bus.O_score, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
